// File: rtl/herm_pkg.sv
// Shared constants and state encoding for the Hermitian-symmetric IFFT input builder.
package herm_pkg;

  localparam int unsigned ACTIVE_SUBCARR = 28;
  localparam int unsigned SYMBOL_NUM     = 8;
  localparam int unsigned FFT_POINT      = 64;
  localparam int unsigned GUARD_LO       = 29;
  localparam int unsigned GUARD_HI       = 35;
  localparam int unsigned MIRROR_LO      = 36;
  localparam int unsigned BUF_DEPTH      = 224;
  localparam int unsigned SAMPLE_W       = 16;
  localparam int unsigned HALF_W         = 8;

  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned BIN_W      = 6;
  localparam int unsigned SYM_W      = 3;
  localparam int unsigned TOTAL_BINS = SYMBOL_NUM * FFT_POINT;
  localparam int unsigned XFER_W     = 9;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/herm_in_buff.sv
// 224x16 simple dual-port sample buffer: one write port, one registered read port.
// Ports: clk; we/waddr/wdata write port; re/raddr/rdata read port (rdata valid one
// cycle after raddr, held while re is low). Contents are never reset.
module herm_in_buff
  import herm_pkg::*;
(
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [SAMPLE_W-1:0] wdata,
  input  logic                re,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [SAMPLE_W-1:0] rdata
);

  logic [SAMPLE_W-1:0] mem [BUF_DEPTH];

  // Plain RAM template with an output register enable so a stalled read holds.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/herm_inserter.sv
// Buffers 224 active subcarrier samples, then emits 8 symbols x 64 IFFT bins with
// DC/guard zeros and a conjugate mirror so the IFFT output is real.
// Ports: clk, rst (async, active-high); din/wren fill side with in_buff_full;
// dout/dout_valid/dout_ready/sym_start output stream; frame_done pulse; tx_done restart.
// Build option: HERM_CONJ_SAT_EN saturates conj of im=-128 to +127.
module herm_inserter
  import herm_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] din,
  input  logic                wren,
  output logic                in_buff_full,
  output logic [SAMPLE_W-1:0] dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                sym_start,
  output logic                frame_done,
  input  logic                tx_done
);

  state_t state, state_nx;

  logic [ADDR_W-1:0]   cnt_in;
  logic [XFER_W:0]     issue_cnt;   // {finished, symbol, bin} of the next read to issue
  logic [XFER_W-1:0]   xfer_cnt;
  logic [BIN_W-1:0]    issue_bin;
  logic [SYM_W-1:0]    issue_sym;
  logic [ADDR_W-1:0]   rd_base, rd_off, rd_addr;
  logic [SAMPLE_W-1:0] rd_data, map_data;
  logic                bin_zero, bin_conj;
  logic                s1_valid, s1_zero, s1_conj, s1_first;
  logic                buf_we, stall, xfer, last_xfer, issue_en;

  // Conjugate: keep re, negate im.
  function automatic logic [SAMPLE_W-1:0] conj(input logic [SAMPLE_W-1:0] s);
    logic [HALF_W-1:0] im_neg;
`ifdef HERM_CONJ_SAT_EN
    if (s[HALF_W-1:0] == {1'b1, {(HALF_W-1){1'b0}}})
      im_neg = {1'b0, {(HALF_W-1){1'b1}}};
    else
      im_neg = HALF_W'(0) - s[HALF_W-1:0];
`else
    im_neg = HALF_W'(0) - s[HALF_W-1:0];
`endif
    return {s[SAMPLE_W-1:HALF_W], im_neg};
  endfunction

  herm_in_buff u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (cnt_in),
    .wdata (din),
    .re    (!stall),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_FILL;
    else     state <= state_nx;
  end

  // Next-state logic; tx_done overrides everything.
  always_comb begin
    state_nx = state;
    if (tx_done) begin
      state_nx = ST_FILL;
    end else begin
      case (state)
        ST_FILL: if (buf_we && cnt_in == ADDR_W'(BUF_DEPTH - 1)) state_nx = ST_EMIT;
        ST_EMIT: if (last_xfer) state_nx = ST_DONE;
        default: state_nx = state;
      endcase
    end
  end

  // Control strobes. A stall freezes the whole read pipeline, RAM output included.
  always_comb begin
    buf_we    = 1'b0;
    stall     = 1'b0;
    xfer      = 1'b0;
    last_xfer = 1'b0;
    issue_en  = 1'b0;
    buf_we    = (state == ST_FILL) && wren && !tx_done;
    stall     = dout_valid && !dout_ready;
    xfer      = (state == ST_EMIT) && dout_valid && dout_ready;
    last_xfer = xfer && (xfer_cnt == XFER_W'(TOTAL_BINS - 1));
    issue_en  = (state == ST_EMIT) && !stall && !issue_cnt[XFER_W];
  end

  // Bin classification and buffer address for the bin being issued.
  always_comb begin
    issue_bin = issue_cnt[BIN_W-1:0];
    issue_sym = issue_cnt[BIN_W +: SYM_W];
    bin_zero  = (issue_bin == '0) ||
                (issue_bin >= BIN_W'(GUARD_LO) && issue_bin <= BIN_W'(GUARD_HI));
    bin_conj  = issue_bin >= BIN_W'(MIRROR_LO);
    rd_base   = ADDR_W'(issue_sym) * ADDR_W'(ACTIVE_SUBCARR);
    rd_off    = '0;
    if (bin_conj)       rd_off = ADDR_W'(FFT_POINT - 1) - ADDR_W'(issue_bin);
    else if (!bin_zero) rd_off = ADDR_W'(issue_bin) - ADDR_W'(1);
    rd_addr   = rd_base + rd_off;
  end

  // Output mapping applied to the registered RAM read.
  always_comb begin
    map_data = rd_data;
    if (s1_zero)      map_data = '0;
    else if (s1_conj) map_data = conj(rd_data);
  end

  // Datapath registers: fill counter, issue/transfer counters, pipeline and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_in       <= '0;
      issue_cnt    <= '0;
      xfer_cnt     <= '0;
      s1_valid     <= 1'b0;
      s1_zero      <= 1'b0;
      s1_conj      <= 1'b0;
      s1_first     <= 1'b0;
      dout         <= '0;
      dout_valid   <= 1'b0;
      sym_start    <= 1'b0;
      frame_done   <= 1'b0;
      in_buff_full <= 1'b0;
    end else if (tx_done) begin
      cnt_in       <= '0;
      issue_cnt    <= '0;
      xfer_cnt     <= '0;
      s1_valid     <= 1'b0;
      dout         <= '0;
      dout_valid   <= 1'b0;
      sym_start    <= 1'b0;
      frame_done   <= 1'b0;
      in_buff_full <= 1'b0;
    end else begin
      if (buf_we) cnt_in <= cnt_in + ADDR_W'(1);
      if (xfer)   xfer_cnt <= xfer_cnt + XFER_W'(1);
      frame_done   <= last_xfer;
      in_buff_full <= (state_nx != ST_FILL);
      if (!stall) begin
        s1_valid   <= issue_en;
        s1_zero    <= bin_zero;
        s1_conj    <= bin_conj;
        s1_first   <= (issue_bin == '0);
        if (issue_en) issue_cnt <= issue_cnt + (XFER_W + 1)'(1);
        dout_valid <= s1_valid;
        dout       <= s1_valid ? map_data : '0;
        sym_start  <= s1_valid && s1_first;
      end
    end
  end

endmodule

// File: tb/tb_herm_inserter.sv
// Self-checking bench for herm_inserter: scoreboard of expected bins built from a
// reference model of the buffer, checked on every transfer by a negedge monitor.
module tb_herm_inserter;

  logic        clk;
  logic        rst;
  logic [15:0] din;
  logic        wren;
  logic        in_buff_full;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        sym_start;
  logic        frame_done;
  logic        tx_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] model [224];
  int          model_cnt;
  logic [16:0] sb_q [$];

  int          cyc = 0;
  int          mon_xfers = 0;
  int          mon_sym = 0;
  int          mon_frames = 0;
  int          first_cyc = 0;
  int          last_cyc = 0;
  logic [15:0] cap [64];
  logic        prev_stall = 1'b0;
  logic        prev_fd = 1'b0;
  logic [15:0] prev_dout = '0;
  logic        prev_ss = 1'b0;

  herm_inserter dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .wren         (wren),
    .in_buff_full (in_buff_full),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .sym_start    (sym_start),
    .frame_done   (frame_done),
    .tx_done      (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference mapping of symbol s, bin n from the bench's copy of the buffer.
  function automatic logic [15:0] exp_bin(input int s, input int n);
    logic [15:0] v;
    logic [7:0]  im;
    if (n == 0 || (n >= 29 && n <= 35)) return 16'h0000;
    if (n <= 28) return model[28 * s + n - 1];
    v  = model[28 * s + 63 - n];
    im = v[7:0];
`ifdef HERM_CONJ_SAT_EN
    if (im == 8'h80) return {v[15:8], 8'h7F};
`endif
    return {v[15:8], 8'h00 - im};
  endfunction

  task automatic push_frame();
    for (int s = 0; s < 8; s++)
      for (int n = 0; n < 64; n++)
        sb_q.push_back({exp_bin(s, n), (n == 0)});
  endtask

  task automatic mon_clear();
    mon_xfers = 0;
    mon_sym   = 0;
  endtask

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    logic [16:0] e;
    cyc++;
    if (rst || tx_done) begin
      prev_stall = 1'b0;
      prev_fd    = 1'b0;
    end else begin
      if (prev_stall) begin
        n_checks++;
        if (dout_valid !== 1'b1 || dout !== prev_dout || sym_start !== prev_ss) begin
          n_fail++;
          $display("FAIL stall_hold: got valid=%b dout=%h ss=%b expected valid=1 dout=%h ss=%b",
                   dout_valid, dout, sym_start, prev_dout, prev_ss);
        end
      end
      if (dout_valid && dout_ready) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_underflow: got dout=%h with no expected bin pending", dout);
        end else begin
          e = sb_q.pop_front();
          if ({dout, sym_start} !== e) begin
            n_fail++;
            $display("FAIL sb_bin xfer=%0d: got dout=%h ss=%b expected dout=%h ss=%b",
                     mon_xfers, dout, sym_start, e[16:1], e[0]);
          end
        end
        if (mon_xfers < 64) cap[mon_xfers] = dout;
        if (sym_start) mon_sym++;
        if (mon_xfers == 0) first_cyc = cyc;
        last_cyc = cyc;
        mon_xfers++;
      end
      if (frame_done) begin
        n_checks++;
        if (prev_fd || mon_xfers != 512 || last_cyc != cyc - 1 || dout_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL frame_done_timing: got xfers=%0d gap=%0d prev_fd=%b valid=%b expected 512/1/0/0",
                   mon_xfers, cyc - last_cyc, prev_fd, dout_valid);
        end
        mon_frames++;
      end
      prev_fd    = frame_done;
      prev_stall = dout_valid && !dout_ready;
      prev_dout  = dout;
      prev_ss    = sym_start;
    end
  end

  // Drive n write pulses; the model keeps the first 224 and queues the frame.
  task automatic fill(input int n, input int mode);
    logic [15:0] d;
    model_cnt = 0;
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       d = {8'(i), 8'(i + 1)};
        2:       d = (i == 0) ? 16'h5A80 : 16'($urandom);
        default: d = 16'($urandom);
      endcase
      if (i >= 224) d = 16'($urandom);
      din  = d;
      wren = 1'b1;
      if (model_cnt < 224) begin
        model[model_cnt] = d;
        model_cnt++;
        if (model_cnt == 224) push_frame();
      end
      @(posedge clk); #1;
      if (i == 222) begin
        n_checks++;
        if (in_buff_full !== 1'b0) begin
          n_fail++;
          $display("FAIL full_early: got in_buff_full=%b expected 0", in_buff_full);
        end
      end
      if (i == 223) begin
        n_checks++;
        if (in_buff_full !== 1'b1) begin
          n_fail++;
          $display("FAIL full_rise: got in_buff_full=%b expected 1", in_buff_full);
        end
      end
    end
    wren = 1'b0;
    din  = '0;
  endtask

  task automatic wait_frame(input int bound, input bit rand_ready);
    int f0;
    int k;
    f0 = mon_frames;
    k  = 0;
    while (mon_frames == f0 && k < bound) begin
      if (rand_ready) dout_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      k++;
    end
    dout_ready = 1'b1;
    n_checks++;
    if (mon_frames == f0) begin
      n_fail++;
      $display("FAIL wait_frame: got no frame_done within %0d cycles expected one", bound);
    end
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; din = '0; wren = 1'b0; dout_ready = 1'b0; tx_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({dout, dout_valid, sym_start, frame_done, in_buff_full} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got dout=%h v=%b ss=%b fd=%b full=%b expected all 0",
               dout, dout_valid, sym_start, frame_done, in_buff_full);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (in_buff_full !== 1'b0 || dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got full=%b valid=%b expected 0 0", in_buff_full, dout_valid);
    end
  endtask

  task automatic test_basic();
    mon_clear();
    dout_ready = 1'b1;
    fill(224, 0);
    @(posedge clk); #1;
    n_checks++;
    if (dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL first_valid_early: got dout_valid=%b expected 0", dout_valid);
    end
    @(posedge clk); #1;
    n_checks++;
    if (dout_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL first_valid_latency: got dout_valid=%b expected 1", dout_valid);
    end
    wait_frame(1000, 1'b0);
    n_checks++;
    if (cap[0] !== 16'h0000 || cap[1] !== 16'h0001 || cap[28] !== 16'h1B1C ||
        cap[36] !== 16'h1BE4 || cap[63] !== 16'h00FF) begin
      n_fail++;
      $display("FAIL sym0_bins: got b0=%h b1=%h b28=%h b36=%h b63=%h expected 0000 0001 1b1c 1be4 00ff",
               cap[0], cap[1], cap[28], cap[36], cap[63]);
    end
    for (int n = 29; n <= 35; n++) begin
      n_checks++;
      if (cap[n] !== 16'h0000) begin
        n_fail++;
        $display("FAIL guard_bin%0d: got %h expected 0000", n, cap[n]);
      end
    end
    n_checks++;
    if (last_cyc - first_cyc != 511 || mon_sym != 8 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL basic_stream: got span=%0d sym_starts=%0d left=%0d expected 511 8 0",
               last_cyc - first_cyc, mon_sym, sb_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (in_buff_full !== 1'b1 || dout_valid !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_hold: got full=%b valid=%b fd=%b expected 1 0 0",
               in_buff_full, dout_valid, frame_done);
    end
    pulse_tx_done();
    n_checks++;
    if (in_buff_full !== 1'b0) begin
      n_fail++;
      $display("FAIL tx_done_clear: got in_buff_full=%b expected 0", in_buff_full);
    end
  endtask

  task automatic test_stall();
    mon_clear();
    dout_ready = 1'b0;
    fill(224, 0);
    wait_frame(4000, 1'b1);
    n_checks++;
    if (mon_sym != 8 || mon_xfers != 512 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL stall_stream: got sym_starts=%0d xfers=%0d left=%0d expected 8 512 0",
               mon_sym, mon_xfers, sb_q.size());
    end
    pulse_tx_done();
  endtask

  task automatic test_conj_sat();
    logic [15:0] want;
`ifdef HERM_CONJ_SAT_EN
    want = 16'h5A7F;
`else
    want = 16'h5A80;
`endif
    mon_clear();
    dout_ready = 1'b1;
    fill(224, 2);
    wait_frame(1000, 1'b0);
    n_checks++;
    if (cap[63] !== want || cap[1] !== 16'h5A80) begin
      n_fail++;
      $display("FAIL conj_min: got b1=%h b63=%h expected 5a80 %h", cap[1], cap[63], want);
    end
    pulse_tx_done();
  endtask

  task automatic test_overfill();
    mon_clear();
    dout_ready = 1'b1;
    fill(230, 1);
    n_checks++;
    if (in_buff_full !== 1'b1) begin
      n_fail++;
      $display("FAIL overfill_full: got in_buff_full=%b expected 1", in_buff_full);
    end
    wait_frame(1000, 1'b0);
    n_checks++;
    if (mon_xfers != 512 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL overfill_stream: got xfers=%0d left=%0d expected 512 0", mon_xfers, sb_q.size());
    end
    pulse_tx_done();
  endtask

  task automatic test_abort();
    int k;
    int f0;
    mon_clear();
    dout_ready = 1'b1;
    fill(224, 1);
    k = 0;
    while (mon_xfers < 299 && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
    n_checks++;
    if (mon_xfers != 299) begin
      n_fail++;
      $display("FAIL abort_reach: got xfers=%0d expected 299", mon_xfers);
    end
    f0 = mon_frames;
    pulse_tx_done();
    n_checks++;
    if (dout_valid !== 1'b0 || in_buff_full !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_clear: got valid=%b full=%b expected 0 0", dout_valid, in_buff_full);
    end
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (mon_frames != f0 || dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_done: got frames=%0d valid=%b expected %0d 0", mon_frames, dout_valid, f0);
    end
    sb_q.delete();
    mon_clear();
    fill(224, 1);
    wait_frame(1000, 1'b0);
    n_checks++;
    if (mon_xfers != 512 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL abort_refill: got xfers=%0d left=%0d expected 512 0", mon_xfers, sb_q.size());
    end
    pulse_tx_done();
  endtask

  task automatic test_rst_mid_emit();
    int k;
    mon_clear();
    dout_ready = 1'b1;
    fill(224, 1);
    k = 0;
    while (mon_xfers < 100 && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({dout, dout_valid, sym_start, frame_done, in_buff_full} !== 20'h0) begin
      n_fail++;
      $display("FAIL async_rst: got dout=%h v=%b ss=%b fd=%b full=%b expected all 0",
               dout, dout_valid, sym_start, frame_done, in_buff_full);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    mon_clear();
    fill(224, 0);
    wait_frame(1000, 1'b0);
    n_checks++;
    if (mon_xfers != 512 || sb_q.size() != 0 || cap[1] !== 16'h0001) begin
      n_fail++;
      $display("FAIL rst_refill: got xfers=%0d left=%0d b1=%h expected 512 0 0001",
               mon_xfers, sb_q.size(), cap[1]);
    end
    pulse_tx_done();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_conj_sat();
    test_overfill();
    test_abort();
    test_rst_mid_emit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/herm_inserter.md
HERM_INSERTER -- requirements
Module: herm_inserter

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge system clock.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: din  input  16  active-subcarrier sample {re[15:8], im[7:0]}, two's complement.
REQ-004 SHALL have port: wren  input  1  din valid; accepted only while in FILL.
REQ-005 SHALL have port: in_buff_full  output  1  all 224 samples captured; further wren ignored.
REQ-006 SHALL have port: dout  output  16  IFFT-input sample {re, im}.
REQ-007 SHALL have port: dout_valid  output  1  dout holds a valid bin.
REQ-008 SHALL have port: dout_ready  input  1  downstream accepts dout when high with dout_valid.
REQ-009 SHALL have port: sym_start  output  1  marks bin 0 of each symbol; qualified by dout_valid.
REQ-010 SHALL have port: frame_done  output  1  single-cycle pulse after bin 63 of symbol 7 is accepted.
REQ-011 SHALL have port: tx_done  input  1  synchronous restart to FILL with empty buffer.

Function
REQ-012 SHALL run a state machine FILL -> EMIT -> DONE, with tx_done returning to FILL.
REQ-013 FILL SHALL write din to buffer address cnt_in (0..223) on each wren, incrementing cnt_in; in_buff_full SHALL rise the cycle after the 224th write, with EMIT entered the same cycle.
REQ-014 EMIT SHALL produce 8 symbols x 64 bins; symbol s, bin n maps as follows.
REQ-015 Mapping for n=0: 16'h0000 (DC).
REQ-016 Mapping for n=1..28: buf[28*s + n-1].
REQ-017 Mapping for n=29..35: 16'h0000 (guard band, includes Nyquist bin 32).
REQ-018 Mapping for n=36..63: conj(buf[28*s + 63-n]), where conj keeps re and negates im.
REQ-019 Transfer SHALL occur when dout_valid && dout_ready; bin counter advances only on transfer.
REQ-020 While dout_valid && !dout_ready, dout, sym_start, and dout_valid SHALL be held stable.
REQ-021 Buffer read latency SHALL be 1 cycle; first dout_valid SHALL assert 2 cycles after EMIT entry; with dout_ready held high, one bin SHALL transfer per cycle with no bubbles (512 consecutive cycles).
REQ-022 After the last transfer, the block SHALL enter DONE, pulse frame_done for 1 cycle, drop dout_valid, and hold in_buff_full=1 until tx_done.
REQ-023 tx_done SHALL win over wren and transfer in the same cycle: cnt_in=0, in_buff_full=0, dout_valid=0, state FILL.
REQ-024 tx_done mid-EMIT SHALL abort the frame without asserting frame_done.
REQ-025 Address arithmetic SHALL be unsigned 8-bit; no address outside 0..223 SHALL be issued.

Reset
REQ-026 On rst, outputs SHALL take these values: dout=0, dout_valid=0, sym_start=0, frame_done=0, in_buff_full=0.
REQ-027 On rst, internal state SHALL reset to state FILL, cnt_in=0, bin/symbol counters=0.
REQ-028 Buffer contents SHALL NOT need reset.
REQ-029 Reset assertion mid-EMIT SHALL take effect asynchronously, and the first cycle after deassertion SHALL be FILL.

Configuration
REQ-030 With HERM_CONJ_SAT_EN defined, conj of im=-128 (8'h80) SHALL yield +127 (8'h7F).
REQ-031 Without HERM_CONJ_SAT_EN, conj SHALL be plain two's-complement negation (8'h80 stays 8'h80).
REQ-032 All other values SHALL be identical in both builds.

Structure
REQ-033 Package herm_pkg SHALL hold these constants: ACTIVE_SUBCARR=28, SYMBOL_NUM=8, FFT_POINT=64, GUARD_LO=29, GUARD_HI=35, MIRROR_LO=36, BUF_DEPTH=224, SAMPLE_W=16, HALF_W=8, and the state enum.
REQ-034 One sub-module herm_in_buff SHALL exist: 224x16 simple dual-port RAM, 1 write port, 1 registered read port, BRAM-inferable.
REQ-035 Mapping logic, conjugation, and the state machine SHALL reside in herm_inserter.

Verification
REQ-036 Write buf[i]={i[7:0], i[7:0]+1} for i=0..223, with dout_ready=1 -> symbol 0 bins SHALL be: bin1=16'h0001, bin28=16'h1B1C, bin36=conj(16'h1B1C)=16'h1BE4, bin63=16'h00FF; bins 0 and 29..35 SHALL be 0; frame_done SHALL pulse 1 cycle after 512 transfers.
REQ-037 Toggle dout_ready randomly at 50% -> the same 512-sample sequence as with ready=1; dout SHALL be stable across every stall; sym_start SHALL assert exactly 8 times, at bins 0.
REQ-038 Write im=8'h80 at buf[0] -> bin 63 of symbol 0 im SHALL be 8'h7F with HERM_CONJ_SAT_EN and 8'h80 without.
REQ-039 Apply 230 wren pulses -> only the first 224 stored, in_buff_full=1 after write 224, and writes 225..230 SHALL have no effect on output.
REQ-040 Assert tx_done at transfer 300 -> dout_valid=0 next cycle, no frame_done; a refill of 224 samples SHALL produce a full correct frame.
REQ-041 Assert rst during EMIT -> all outputs 0 immediately (asynchronously), state FILL after release, cnt_in restarting at 0.
